uart_tx_fifo: RTL

//   Byte FIFO feeding the UART transmitter (tx_data_valid/tx_data/tx_ready side of UART_Top).

---
 rtl/uart_tx_fifo_pkg.sv | 12 +
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo_ram.sv | 17 +
 rtl/uart_tx_fifo.sv | 68 ++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared sizes and drain FSM encoding for the UART TX byte FIFO
package uart_tx_fifo_pkg;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2,
    D_BUSY  = 2'd3
  } drain_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer, control and transmitter-side signals of the UART TX FIFO
interface uart_tx_fifo_if;
  import uart_tx_fifo_pkg::*;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              flush;
  logic              clr_overflow;
  logic              tx_ready;
  logic              tx_data_valid;
  logic [DATA_W-1:0] tx_data;
  logic [AW:0]       level;
  logic              overflow;
  logic              idle;
  modport master (
    output wr_valid, wr_data, flush, clr_overflow, tx_ready,
    input  wr_ready, tx_data_valid, tx_data, level, overflow, idle
  );
  modport slave (
    input  wr_valid, wr_data, flush, clr_overflow, tx_ready,
    output wr_ready, tx_data_valid, tx_data, level, overflow, idle
  );
endinterface

// File: rtl/uart_tx_fifo_ram.sv
// uart_tx_fifo_ram: DEPTH x DATA_W storage, synchronous write, combinational read
module uart_tx_fifo_ram
  import uart_tx_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage is not reset: contents are only meaningful below the level count
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining one-cycle valid pulses into the UART transmitter
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
(
  input logic clk,
  input logic reset,
  uart_tx_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  drain_t            state, state_n;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [DATA_W-1:0] rd_data, tx_data;
  logic              full, empty, wr_en, pop, overflow, tx_data_valid;
  assign full  = level == FULL_LVL;
  assign empty = level == '0;
  assign wr_en = bus.wr_valid && !full && !bus.flush;
  assign bus.wr_ready      = !full;
  assign bus.level         = level;
  assign bus.overflow      = overflow;
  assign bus.tx_data       = tx_data;
  assign bus.tx_data_valid = tx_data_valid;
  assign bus.idle          = empty && state == D_IDLE;
  uart_tx_fifo_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
  // pop only from idle so a second pulse needs tx_ready to fall and rise again
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      D_IDLE: begin
        pop     = !empty && bus.tx_ready && !bus.flush;
        state_n = pop ? D_ISSUE : D_IDLE;
      end
      D_ISSUE: state_n = D_WAIT;
      D_WAIT:  state_n = bus.tx_ready ? D_WAIT : D_BUSY;
      D_BUSY:  state_n = bus.tx_ready ? D_IDLE : D_BUSY;
      default: state_n = D_IDLE;
    endcase
  end
  // drain FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= D_IDLE;
    else state <= state_n;
  // pointers, level, sticky overflow and the registered transmit byte/pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      wr_ptr        <= bus.flush ? '0 : wr_ptr + AW'(wr_en);
      rd_ptr        <= bus.flush ? '0 : rd_ptr + AW'(pop);
      level         <= bus.flush ? '0 : level + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow      <= (bus.wr_valid && full && !bus.flush) || (overflow && !bus.clr_overflow);
      tx_data       <= pop ? rd_data : tx_data;
      tx_data_valid <= pop;
    end
endmodule
